// File: rtl/hsv_core_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : hsv_core_pkg / hsv_core_issue_dec_if / hsv_core_issue_mux_if
//  Brief    : Core-wide types plus the decode-side and mux-side bundles of
//             the issue buffer.
//  Revision : 1.0 - initial release
// ============================================================================

package hsv_core_pkg;
  typedef logic [31:0] word_t;
  typedef logic [31:0] reg_mask_t;
  typedef logic [4:0]  reg_idx_t;

  // Opaque to the issue buffer; carried through untouched.
  typedef struct packed {
    word_t pc;
    word_t insn;
  } issue_data_t;
endpackage

interface hsv_core_issue_dec_if;
  import hsv_core_pkg::*;

  logic        dec_valid_i;
  logic        dec_ready_o;
  issue_data_t dec_data_i;
  reg_idx_t    dec_rs1_i;
  reg_idx_t    dec_rs2_i;
  reg_idx_t    dec_rd_i;
  logic        dec_uses_rs1_i;
  logic        dec_uses_rs2_i;
  logic        dec_writes_rd_i;

  modport master (
    output dec_valid_i, dec_data_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
           dec_uses_rs1_i, dec_uses_rs2_i, dec_writes_rd_i,
    input  dec_ready_o
  );

  modport slave (
    input  dec_valid_i, dec_data_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
           dec_uses_rs1_i, dec_uses_rs2_i, dec_writes_rd_i,
    output dec_ready_o
  );
endinterface

interface hsv_core_issue_mux_if;
  import hsv_core_pkg::*;

  logic        flush_req;
  logic        stall;
  logic        hazard;
  logic        valid_o;
  issue_data_t issue_data_o;
  reg_mask_t   mask_o;
  reg_mask_t   rd_mask_o;
  reg_idx_t    rf_rs1_addr_o;
  reg_idx_t    rf_rs2_addr_o;

  modport master (
    input  flush_req, stall, hazard,
    output valid_o, issue_data_o, mask_o, rd_mask_o,
           rf_rs1_addr_o, rf_rs2_addr_o
  );

  modport slave (
    output flush_req, stall, hazard,
    input  valid_o, issue_data_o, mask_o, rd_mask_o,
           rf_rs1_addr_o, rf_rs2_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/hsv_core_issue.sv
`default_nettype none
// ============================================================================
//  Module   : hsv_core_issue
//  Brief    : Two-entry in-order issue buffer between decode and the operand
//             muxing stage, with precomputed source/destination masks.
//  Revision : 1.0 - initial release
// ============================================================================

module hsv_core_issue
  import hsv_core_pkg::*;
(
  input  wire logic            clk_core,
  input  wire logic            rst_core,
  hsv_core_issue_dec_if.slave  dec,
  hsv_core_issue_mux_if.master iss
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  typedef struct packed {
    issue_data_t data;
    reg_mask_t   mask;
    reg_mask_t   rd_mask;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
  } entry_t;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_ready;
  entry_t     r_e0;
  entry_t     r_e1;
  entry_t     w_in;
  reg_idx_t   r_rs1_hold;
  reg_idx_t   r_rs2_hold;
  reg_idx_t   w_rf_rs1;
  reg_idx_t   w_rf_rs2;
  logic       w_push;
  logic       w_pop;
  logic       w_valid;

  assign w_valid = (r_state != S_EMPTY);
  assign w_push  = dec.dec_valid_i & r_ready;
  assign w_pop   = w_valid & ~iss.stall & ~iss.hazard;

  // Incoming entry: masks are built once here so the mux stage never decodes.
  always_comb begin
    w_in         = '0;
    w_in.data    = dec.dec_data_i;
    w_in.rs1     = dec.dec_uses_rs1_i ? dec.dec_rs1_i : '0;
    w_in.rs2     = dec.dec_uses_rs2_i ? dec.dec_rs2_i : '0;
    w_in.mask    = ((dec.dec_uses_rs1_i ? (reg_mask_t'(1) << dec.dec_rs1_i) : '0)
                  | (dec.dec_uses_rs2_i ? (reg_mask_t'(1) << dec.dec_rs2_i) : '0))
                  & ~reg_mask_t'(1);
    w_in.rd_mask = (dec.dec_writes_rd_i && (dec.dec_rd_i != '0))
                  ? (reg_mask_t'(1) << dec.dec_rd_i) : '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (iss.flush_req) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = S_TWO;
          else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Read addresses track next cycle's head so RF data lines up with it.
  always_comb begin
    w_rf_rs1 = r_rs1_hold;
    w_rf_rs2 = r_rs2_hold;
    if ((r_state == S_TWO) && w_pop) begin
      w_rf_rs1 = r_e1.rs1;
      w_rf_rs2 = r_e1.rs2;
    end else if ((w_pop || (r_state == S_EMPTY)) && w_push) begin
      w_rf_rs1 = w_in.rs1;
      w_rf_rs2 = w_in.rs2;
    end else if (w_valid && !w_pop) begin
      w_rf_rs1 = r_e0.rs1;
      w_rf_rs2 = r_e0.rs2;
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_state    <= S_EMPTY;
      r_ready    <= 1'b1;
      r_rs1_hold <= '0;
      r_rs2_hold <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= (w_state_nxt != S_TWO);
      r_rs1_hold <= w_rf_rs1;
      r_rs2_hold <= w_rf_rs2;
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_e0 <= '0;
      r_e1 <= '0;
    end else if (!iss.flush_req) begin
      case (r_state)
        S_EMPTY: if (w_push) r_e0 <= w_in;
        S_ONE: begin
          if (w_push && w_pop) r_e0 <= w_in;
          else if (w_push)     r_e1 <= w_in;
        end
        S_TWO:   if (w_pop) r_e0 <= r_e1;
        default: ;
      endcase
    end
  end

  assign dec.dec_ready_o   = r_ready;
  assign iss.valid_o       = w_valid;
  assign iss.issue_data_o  = r_e0.data;
  assign iss.mask_o        = w_valid ? r_e0.mask    : '0;
  assign iss.rd_mask_o     = w_valid ? r_e0.rd_mask : '0;
  assign iss.rf_rs1_addr_o = w_rf_rs1;
  assign iss.rf_rs2_addr_o = w_rf_rs2;

endmodule

`default_nettype wire

// File: tb/tb_hsv_core_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hsv_core_issue
//  Brief    : Directed self-checking bench for the two-entry issue buffer.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_hsv_core_issue;
  import hsv_core_pkg::*;

  logic clk_core;
  logic rst_core;
  int   n_checks;
  int   n_fail;

  hsv_core_issue_dec_if dec_if ();
  hsv_core_issue_mux_if mux_if ();

  hsv_core_issue u_dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .dec      (dec_if),
    .iss      (mux_if)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required end of test earlier");
    $fatal(1);
  end

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wr, input logic [31:0] tag);
    dec_if.dec_valid_i     = 1'b1;
    dec_if.dec_rs1_i       = rs1;
    dec_if.dec_rs2_i       = rs2;
    dec_if.dec_rd_i        = rd;
    dec_if.dec_uses_rs1_i  = u1;
    dec_if.dec_uses_rs2_i  = u2;
    dec_if.dec_writes_rd_i = wr;
    dec_if.dec_data_i      = '{pc: tag, insn: ~tag};
  endtask

  task automatic idle();
    dec_if.dec_valid_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_core);
    #1;
  endtask

  task automatic test_reset();
    rst_core = 1'b1;
    idle();
    dec_if.dec_rs1_i = '0; dec_if.dec_rs2_i = '0; dec_if.dec_rd_i = '0;
    dec_if.dec_uses_rs1_i = 0; dec_if.dec_uses_rs2_i = 0; dec_if.dec_writes_rd_i = 0;
    dec_if.dec_data_i = '0;
    mux_if.flush_req = 0; mux_if.stall = 0; mux_if.hazard = 0;
    #2;
    n_checks++; if (mux_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mux_if.valid_o); end
    n_checks++; if (dec_if.dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", dec_if.dec_ready_o); end
    n_checks++; if (mux_if.mask_o !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", mux_if.mask_o); end
    n_checks++; if (mux_if.rd_mask_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdmask: got %h want 0", mux_if.rd_mask_o); end
    n_checks++; if (mux_if.rf_rs1_addr_o !== 5'd0 || mux_if.rf_rs2_addr_o !== 5'd0) begin n_fail++;
      $display("FAIL reset_rfaddr: got %0d/%0d want 0/0", mux_if.rf_rs1_addr_o, mux_if.rf_rs2_addr_o); end
    repeat (2) @(posedge clk_core);
    #1 rst_core = 1'b0;
  endtask

  task automatic test_single_push();
    offer(5'd3, 5'd5, 5'd7, 1, 1, 1, 32'h0000_00A0);
    #1;
    n_checks++; if (dec_if.dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", dec_if.dec_ready_o); end
    n_checks++; if (mux_if.rf_rs1_addr_o !== 5'd3 || mux_if.rf_rs2_addr_o !== 5'd5) begin n_fail++;
      $display("FAIL single_rfaddr: got %0d/%0d want 3/5", mux_if.rf_rs1_addr_o, mux_if.rf_rs2_addr_o); end
    next_cycle();
    idle();
    #1;
    n_checks++; if (mux_if.valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", mux_if.valid_o); end
    n_checks++; if (mux_if.mask_o !== 32'h28) begin n_fail++; $display("FAIL single_mask: got %h want 28", mux_if.mask_o); end
    n_checks++; if (mux_if.rd_mask_o !== 32'h80) begin n_fail++; $display("FAIL single_rdmask: got %h want 80", mux_if.rd_mask_o); end
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hA0) begin n_fail++; $display("FAIL single_data: got %h want a0", mux_if.issue_data_o.pc); end
    next_cycle();
    n_checks++; if (mux_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", mux_if.valid_o); end
  endtask

  task automatic test_back_to_back();
    mux_if.stall = 1'b1;
    offer(5'd1, 5'd2, 5'd10, 1, 1, 1, 32'h0000_0A01);
    next_cycle();
    offer(5'd3, 5'd4, 5'd11, 1, 1, 1, 32'h0000_0B02);
    #1;
    n_checks++; if (dec_if.dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %b want 1", dec_if.dec_ready_o); end
    next_cycle();
    offer(5'd5, 5'd6, 5'd12, 1, 1, 1, 32'h0000_0C03);
    #1;
    n_checks++; if (dec_if.dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", dec_if.dec_ready_o); end
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hA01 || mux_if.valid_o !== 1'b1) begin n_fail++;
      $display("FAIL b2b_head_a: got %h/%b want a01/1", mux_if.issue_data_o.pc, mux_if.valid_o); end
    n_checks++; if (mux_if.rd_mask_o !== 32'h400) begin n_fail++; $display("FAIL b2b_rdmask_a: got %h want 400", mux_if.rd_mask_o); end
    n_checks++; if (mux_if.rf_rs1_addr_o !== 5'd1) begin n_fail++; $display("FAIL b2b_rf_hold: got %0d want 1", mux_if.rf_rs1_addr_o); end
    next_cycle();
    mux_if.stall = 1'b0;
    #1;
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hA01) begin n_fail++; $display("FAIL b2b_pop_a: got %h want a01", mux_if.issue_data_o.pc); end
    n_checks++; if (mux_if.rf_rs1_addr_o !== 5'd3 || mux_if.rf_rs2_addr_o !== 5'd4) begin n_fail++;
      $display("FAIL b2b_rf_e1: got %0d/%0d want 3/4", mux_if.rf_rs1_addr_o, mux_if.rf_rs2_addr_o); end
    next_cycle();
    #1;
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hB02 || dec_if.dec_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL b2b_head_b: got %h/%b want b02/1", mux_if.issue_data_o.pc, dec_if.dec_ready_o); end
    n_checks++; if (mux_if.rf_rs1_addr_o !== 5'd5) begin n_fail++; $display("FAIL b2b_rf_in: got %0d want 5", mux_if.rf_rs1_addr_o); end
    next_cycle();
    idle();
    #1;
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hC03 || mux_if.valid_o !== 1'b1) begin n_fail++;
      $display("FAIL b2b_head_c: got %h/%b want c03/1", mux_if.issue_data_o.pc, mux_if.valid_o); end
    n_checks++; if (mux_if.mask_o !== 32'h60) begin n_fail++; $display("FAIL b2b_mask_c: got %h want 60", mux_if.mask_o); end
    next_cycle();
    n_checks++; if (mux_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", mux_if.valid_o); end
  endtask

  task automatic test_hazard();
    mux_if.hazard = 1'b1;
    offer(5'd7, 5'd8, 5'd1, 1, 1, 1, 32'h0000_00A1);
    next_cycle();
    offer(5'd9, 5'd10, 5'd2, 1, 1, 1, 32'h0000_00B1);
    #1;
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hA1 || mux_if.valid_o !== 1'b1) begin n_fail++;
      $display("FAIL haz_head1: got %h/%b want a1/1", mux_if.issue_data_o.pc, mux_if.valid_o); end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      idle();
      #1;
      n_checks++; if (mux_if.issue_data_o.pc !== 32'hA1 || mux_if.mask_o !== 32'h180 || mux_if.rd_mask_o !== 32'h2) begin n_fail++;
        $display("FAIL haz_hold%0d: got %h/%h/%h want a1/180/2", i, mux_if.issue_data_o.pc, mux_if.mask_o, mux_if.rd_mask_o); end
    end
    next_cycle();
    mux_if.hazard = 1'b0;
    #1;
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hA1 || mux_if.rf_rs1_addr_o !== 5'd9) begin n_fail++;
      $display("FAIL haz_release: got %h/%0d want a1/9", mux_if.issue_data_o.pc, mux_if.rf_rs1_addr_o); end
    next_cycle();
    n_checks++; if (mux_if.issue_data_o.pc !== 32'hB1 || mux_if.mask_o !== 32'h600) begin n_fail++;
      $display("FAIL haz_head_b: got %h/%h want b1/600", mux_if.issue_data_o.pc, mux_if.mask_o); end
    next_cycle();
    n_checks++; if (mux_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL haz_drain: got %b want 0", mux_if.valid_o); end
  endtask

  task automatic test_zero_regs();
    offer(5'd0, 5'd9, 5'd0, 1, 1, 1, 32'h0000_0Z01 & 32'h0000_0F01);
    #1;
    n_checks++; if (mux_if.rf_rs1_addr_o !== 5'd0 || mux_if.rf_rs2_addr_o !== 5'd9) begin n_fail++;
      $display("FAIL zero_rfaddr: got %0d/%0d want 0/9", mux_if.rf_rs1_addr_o, mux_if.rf_rs2_addr_o); end
    next_cycle();
    offer(5'd4, 5'd12, 5'd31, 1, 0, 1, 32'h0000_0F02);
    #1;
    n_checks++; if (mux_if.mask_o !== 32'h200) begin n_fail++; $display("FAIL zero_mask: got %h want 200", mux_if.mask_o); end
    n_checks++; if (mux_if.rd_mask_o !== 32'h0) begin n_fail++; $display("FAIL zero_rdmask: got %h want 0", mux_if.rd_mask_o); end
    n_checks++; if (mux_if.rf_rs1_addr_o !== 5'd4 || mux_if.rf_rs2_addr_o !== 5'd0) begin n_fail++;
      $display("FAIL unused_rfaddr: got %0d/%0d want 4/0", mux_if.rf_rs1_addr_o, mux_if.rf_rs2_addr_o); end
    next_cycle();
    idle();
    #1;
    n_checks++; if (mux_if.mask_o !== 32'h10 || mux_if.rd_mask_o !== 32'h8000_0000) begin n_fail++;
      $display("FAIL rd31_masks: got %h/%h want 10/80000000", mux_if.mask_o, mux_if.rd_mask_o); end
    next_cycle();
    n_checks++; if (mux_if.mask_o !== 32'h0 || mux_if.rd_mask_o !== 32'h0) begin n_fail++;
      $display("FAIL empty_masks: got %h/%h want 0/0", mux_if.mask_o, mux_if.rd_mask_o); end
  endtask

  task automatic test_flush();
    mux_if.stall = 1'b1;
    offer(5'd1, 5'd2, 5'd3, 1, 1, 1, 32'h0000_0FA0);
    next_cycle();
    offer(5'd4, 5'd5, 5'd6, 1, 1, 1, 32'h0000_0FB0);
    next_cycle();
    offer(5'd7, 5'd8, 5'd9, 1, 1, 1, 32'h0000_0FD0);
    mux_if.flush_req = 1'b1;
    next_cycle();
    mux_if.flush_req = 1'b0;
    idle();
    #1;
    n_checks++; if (mux_if.valid_o !== 1'b0 || dec_if.dec_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL flush_two: got valid %b ready %b want 0/1", mux_if.valid_o, dec_if.dec_ready_o); end
    offer(5'd1, 5'd1, 5'd1, 1, 1, 1, 32'h0000_0FE0);
    next_cycle();
    offer(5'd2, 5'd2, 5'd2, 1, 1, 1, 32'h0000_0FF0);
    mux_if.flush_req = 1'b1;
    next_cycle();
    mux_if.flush_req = 1'b0;
    mux_if.stall = 1'b0;
    idle();
    #1;
    n_checks++; if (mux_if.valid_o !== 1'b0 || dec_if.dec_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL flush_one: got valid %b ready %b want 0/1", mux_if.valid_o, dec_if.dec_ready_o); end
    next_cycle();
    n_checks++; if (mux_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", mux_if.valid_o); end
  endtask

  task automatic test_async_reset();
    mux_if.stall = 1'b1;
    offer(5'd3, 5'd3, 5'd3, 1, 1, 1, 32'h0000_0AA0);
    next_cycle();
    idle();
    #1;
    n_checks++; if (mux_if.valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b want 1", mux_if.valid_o); end
    rst_core = 1'b1;
    #1;
    n_checks++; if (mux_if.valid_o !== 1'b0 || mux_if.mask_o !== 32'h0) begin n_fail++;
      $display("FAIL arst_async: got valid %b mask %h want 0/0", mux_if.valid_o, mux_if.mask_o); end
    next_cycle();
    rst_core = 1'b0;
    mux_if.stall = 1'b0;
    #1;
    n_checks++; if (dec_if.dec_ready_o !== 1'b1 || mux_if.valid_o !== 1'b0) begin n_fail++;
      $display("FAIL arst_post: got ready %b valid %b want 1/0", dec_if.dec_ready_o, mux_if.valid_o); end
    next_cycle();
    n_checks++; if (mux_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_nothing: got %b want 0", mux_if.valid_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_push();
    test_back_to_back();
    test_hazard();
    test_zero_regs();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hsv_core_issue.md
HSV_CORE_ISSUE -- requirements
Module: hsv_core_issue

Interface
REQ-001 Parameter: none; widths come from hsv_core_pkg (word = 32 bits, reg_mask = 32 bits, one bit per x register, issue_data_t opaque payload).
REQ-002 clk_core  in  1  core clock; all state updates on its rising edge.
REQ-003 rst_core  in  1  reset, asynchronous assert, active-high.
REQ-004 flush_req  in  1  discard all buffered instructions.
REQ-005 stall  in  1  muxing stage cannot accept this cycle.
REQ-006 hazard  in  1  muxing stage reports a scoreboard conflict for the presented instruction.
REQ-007 dec_valid_i  in  1  decoded instruction offered.
REQ-008 dec_ready_o  out  1  this block accepts the offered instruction this cycle.
REQ-009 dec_data_i  in  issue_data_t  decoded payload.
REQ-010 dec_rs1_i, dec_rs2_i, dec_rd_i  in  5 each  register indices.
REQ-011 dec_uses_rs1_i, dec_uses_rs2_i, dec_writes_rd_i  in  1 each  operand/destination usage flags.
REQ-012 rf_rs1_addr_o, rf_rs2_addr_o  out  5 each  register-file read addresses (file has 1-cycle synchronous read).
REQ-013 valid_o  out  1  head instruction presented to the muxing stage.
REQ-014 issue_data_o  out  issue_data_t  head payload.
REQ-015 mask_o  out  32  source-register mask of head.
REQ-016 rd_mask_o  out  32  destination mask of head.

Function
REQ-017 Buffer: 2 entries, in-order; states EMPTY (0), ONE (1), TWO (2); the head is entry 0.
REQ-018 Push = dec_valid_i & dec_ready_o; pop = valid_o & ~stall & ~hazard.
REQ-019 dec_ready_o is a registered signal, equal to (next state != TWO); it is independent of dec_valid_i in the same cycle.
REQ-020 Transitions: EMPTY+push→ONE; ONE+push&~pop→TWO; ONE+pop&~push→EMPTY; ONE+push&pop→ONE with new head = incoming; TWO+pop→ONE with entry1 moved to head; no push in TWO.
REQ-021 Latency: an instruction accepted in cycle N with an empty buffer is presented as valid_o in cycle N+1.
REQ-022 valid_o = (state != EMPTY); the head is held unchanged while stall or hazard is asserted.
REQ-023 mask_o bit i = (uses_rs1 & rs1==i) | (uses_rs2 & rs2==i); bit 0 is always 0; the mask is computed at push and stored per entry.
REQ-024 rd_mask_o = one-hot(rd) when writes_rd & rd!=0, else all zeros; the mask is stored per entry.
REQ-025 rf_rs1_addr_o/rf_rs2_addr_o select the instruction that will be head next cycle: the current head if no pop; entry1 if pop in TWO; the incoming instruction if pop or EMPTY with push; otherwise the value is held. This makes rs1/rs2 data aligned with the head.
REQ-026 Unused sources drive read address 0.
REQ-027 flush_req has priority over push and pop: the next state is EMPTY, the incoming instruction is dropped, and dec_ready_o is 1 next cycle.
REQ-028 Payloads of empty entries are don't-care, but valid_o, mask_o and rd_mask_o are 0 whenever the state is EMPTY.

Reset
REQ-029 On rst_core: state EMPTY; valid_o=0, dec_ready_o=1, mask_o=0, rd_mask_o=0, rf_rs1_addr_o=0, rf_rs2_addr_o=0; this applies immediately and asynchronously.
REQ-030 Reset mid-operation discards all entries; no instruction is presented after deassertion until a new push.

Verification
REQ-031 Single push (rs1=3, rs2=5, rd=7, all used), stall=hazard=0 -> cycle+1: valid_o=1, mask_o=0x28, rd_mask_o=0x80, rf addrs 3/5 driven in the push cycle; cycle+2: valid_o=0.
REQ-032 Push A, B, C back-to-back with stall=1 -> A and B buffered, dec_ready_o=0 before C is accepted; release stall -> A, B, C presented in order, one per cycle.
REQ-033 hazard=1 for 3 cycles on head A -> A is held with unchanged outputs; on hazard=0, A pops and B follows next cycle.
REQ-034 rd=0 with writes_rd=1, rs1=0 with uses_rs1=1 -> rd_mask_o=0, mask_o bit0=0, rf_rs1_addr_o=0.
REQ-035 State TWO, then flush_req together with dec_valid_i -> next cycle: valid_o=0, dec_ready_o=1, and the incoming instruction never appears.
REQ-036 Assert rst_core asynchronously while in state ONE -> valid_o drops to 0 before the next clock edge; after deassertion, dec_ready_o=1.
